// File: rtl/biquad_pkg.sv
// Shared types and helpers for the cascaded Direct Form I biquad equaliser.
package biquad_pkg;

  localparam int DEF_DATA_W    = 24;
  localparam int DEF_COEF_W    = 18;
  localparam int DEF_COEF_FRAC = 14;
  localparam int DEF_N_BANDS   = 3;
  localparam int DEF_BAND_AW   = 4;
  localparam int N_TAPS        = 5;
  localparam int COEF_ONE      = 1 << DEF_COEF_FRAC;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  function automatic longint coef_one(input int frac);
    return longint'(1) << frac;
  endfunction

  // Round half-up by adding half an LSB before the arithmetic shift, then clip.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac,
                                                   input int out_w,
                                                   output logic sat);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r   = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    sat = 1'b0;
    if (r > hi) begin
      r   = hi;
      sat = 1'b1;
    end else if (r < lo) begin
      r   = lo;
      sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/biquad_cascade_if.sv
// Sample stream and coefficient port of biquad_cascade.
// Optional i_bypass appears when BIQUAD_CASCADE_BYPASS_EN is defined.
interface biquad_cascade_if
  import biquad_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int BAND_AW = DEF_BAND_AW
`ifdef BIQUAD_CASCADE_BYPASS_EN
  , parameter int N_BANDS = DEF_N_BANDS
`endif
);

  logic                      i_valid;
  logic                      o_ready;
  logic signed [DATA_W-1:0]  i_data;
  logic                      o_valid;
  logic signed [DATA_W-1:0]  o_data;
  logic                      i_coef_we;
  logic [BAND_AW-1:0]        i_coef_band;
  logic [2:0]                i_coef_idx;
  logic signed [COEF_W-1:0]  i_coef;
  logic                      i_coef_commit;
  logic                      o_sat;
`ifdef BIQUAD_CASCADE_BYPASS_EN
  logic [N_BANDS-1:0]        i_bypass;
`endif

  modport master (
    output i_valid, i_data, i_coef_we, i_coef_band, i_coef_idx, i_coef, i_coef_commit,
`ifdef BIQUAD_CASCADE_BYPASS_EN
    output i_bypass,
`endif
    input  o_ready, o_valid, o_data, o_sat
  );

  modport slave (
    input  i_valid, i_data, i_coef_we, i_coef_band, i_coef_idx, i_coef, i_coef_commit,
`ifdef BIQUAD_CASCADE_BYPASS_EN
    input  i_bypass,
`endif
    output o_ready, o_valid, o_data, o_sat
  );

endinterface

// File: rtl/biquad_mac.sv
// Combinational multiply-accumulate step shared by every band, with the
// round/shift/saturate view of the updated accumulator.
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC,
  parameter int ACC_W     = DEF_DATA_W + DEF_COEF_W + 3
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic                     i_sub,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic signed [DATA_W-1:0] o_y,
  output logic                     o_sat
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic signed [63:0]       y_wide;

  always_comb begin
    prod   = PROD_W'(i_x) * PROD_W'(i_coef);
    term   = ACC_W'(prod);
    o_acc  = i_sub ? (i_acc - term) : (i_acc + term);
    y_wide = round_sat(64'(o_acc), COEF_FRAC, DATA_W, o_sat);
    o_y    = DATA_W'(y_wide);
  end

endmodule

// File: rtl/biquad_cascade.sv
// N-band cascaded Direct Form I biquad equaliser on one time-shared multiplier,
// with double-buffered coefficients. Define BIQUAD_CASCADE_BYPASS_EN for per-band bypass.
module biquad_cascade
  import biquad_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC,
  parameter int N_BANDS   = DEF_N_BANDS,
  parameter int BAND_AW   = DEF_BAND_AW
) (
  input logic              i_clk,
  input logic              i_rst_n,
  biquad_cascade_if.slave  bus
);

  localparam int ACC_W  = DATA_W + COEF_W + 3;
  localparam int BIDX_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam logic signed [COEF_W-1:0] COEF_UNITY = COEF_W'(coef_one(COEF_FRAC));

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  state_e                   state_q, state_d;
  logic [BIDX_W-1:0]        band_q, band_d;
  coef_idx_e                idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  sample_t                  xin_q, xin_d;
  sample_t                  data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     sat_q, sat_d;
  logic                     pend_q, pend_d;

  coef_t   act_q [N_BANDS][N_TAPS];
  coef_t   act_d [N_BANDS][N_TAPS];
  coef_t   shd_q [N_BANDS][N_TAPS];
  coef_t   shd_d [N_BANDS][N_TAPS];
  sample_t x1_q [N_BANDS];
  sample_t x1_d [N_BANDS];
  sample_t x2_q [N_BANDS];
  sample_t x2_d [N_BANDS];
  sample_t y1_q [N_BANDS];
  sample_t y1_d [N_BANDS];
  sample_t y2_q [N_BANDS];
  sample_t y2_d [N_BANDS];

  logic [N_BANDS-1:0] run_mask;
`ifdef BIQUAD_CASCADE_BYPASS_EN
  logic [N_BANDS-1:0] byp_q, byp_d;
`endif

  logic                    coef_wr_ok;
  logic                    first_found, next_found;
  logic [BIDX_W-1:0]       first_band, next_band;
  sample_t                 mac_x, mac_y;
  coef_t                   mac_c;
  logic                    mac_sub, mac_sat;
  logic signed [ACC_W-1:0] mac_acc;

  assign coef_wr_ok = bus.i_coef_we && (bus.i_coef_idx <= 3'(A2))
                      && (int'(bus.i_coef_band) < N_BANDS);

  // Lowest running band overall, and lowest running band above the current one.
  always_comb begin
`ifdef BIQUAD_CASCADE_BYPASS_EN
    run_mask = (state_q == S_IDLE) ? ~bus.i_bypass : ~byp_q;
`else
    run_mask = '1;
`endif
    first_found = 1'b0;
    first_band  = '0;
    next_found  = 1'b0;
    next_band   = '0;
    for (int i = N_BANDS - 1; i >= 0; i--) begin
      if (run_mask[i]) begin
        first_found = 1'b1;
        first_band  = BIDX_W'(i);
        if (i > int'(band_q)) begin
          next_found = 1'b1;
          next_band  = BIDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    mac_c   = act_q[band_q][idx_q];
    mac_sub = (idx_q == A1) || (idx_q == A2);
    case (idx_q)
      B0:      mac_x = xin_q;
      B1:      mac_x = x1_q[band_q];
      B2:      mac_x = x2_q[band_q];
      A1:      mac_x = y1_q[band_q];
      default: mac_x = y2_q[band_q];
    endcase
  end

  biquad_mac #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .ACC_W     (ACC_W)
  ) u_mac (
    .i_acc  (acc_q),
    .i_x    (mac_x),
    .i_coef (mac_c),
    .i_sub  (mac_sub),
    .o_acc  (mac_acc),
    .o_y    (mac_y),
    .o_sat  (mac_sat)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    band_d  = band_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    xin_d   = xin_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sat_d   = sat_q;
    pend_d  = pend_q | bus.i_coef_commit;
    shd_d   = shd_q;
    act_d   = act_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
`ifdef BIQUAD_CASCADE_BYPASS_EN
    byp_d   = byp_q;
`endif

    if (coef_wr_ok) begin
      shd_d[bus.i_coef_band[BIDX_W-1:0]][bus.i_coef_idx] = bus.i_coef;
    end

    case (state_q)
      S_IDLE: begin
        // Copy from shd_d so a write landing with the commit is included.
        if (pend_d) begin
          act_d  = shd_d;
          pend_d = 1'b0;
        end
        if (bus.i_valid) begin
          xin_d = bus.i_data;
          acc_d = '0;
          idx_d = B0;
`ifdef BIQUAD_CASCADE_BYPASS_EN
          byp_d = bus.i_bypass;
`endif
          if (first_found) begin
            band_d  = first_band;
            state_d = S_MAC;
          end else begin
            data_d  = bus.i_data;
            valid_d = 1'b1;
            state_d = S_OUT;
          end
        end
      end

      S_MAC: begin
        acc_d = mac_acc;
        idx_d = coef_idx_e'(idx_q + 3'd1);
        if (idx_q == A2) begin
          acc_d          = '0;
          idx_d          = B0;
          x2_d[band_q]   = x1_q[band_q];
          x1_d[band_q]   = xin_q;
          y2_d[band_q]   = y1_q[band_q];
          y1_d[band_q]   = mac_y;
          xin_d          = mac_y;
          sat_d          = sat_q | mac_sat;
          if (next_found) begin
            band_d = next_band;
          end else begin
            data_d  = mac_y;
            valid_d = 1'b1;
            state_d = S_OUT;
          end
        end
      end

      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      band_q  <= '0;
      idx_q   <= B0;
      acc_q   <= '0;
      xin_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      pend_q  <= 1'b0;
`ifdef BIQUAD_CASCADE_BYPASS_EN
      byp_q   <= '0;
`endif
      // NOTE: coefficient banks and history are plain registers and are reset on
      // purpose, so reset restores a clean passthrough filter with no ringing.
      for (int b = 0; b < N_BANDS; b++) begin
        x1_q[b] <= '0;
        x2_q[b] <= '0;
        y1_q[b] <= '0;
        y2_q[b] <= '0;
        for (int k = 0; k < N_TAPS; k++) begin
          act_q[b][k] <= (k == 0) ? COEF_UNITY : '0;
          shd_q[b][k] <= (k == 0) ? COEF_UNITY : '0;
        end
      end
    end else begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // the values from before this edge.
      state_q <= state_d;
      band_q  <= band_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      xin_q   <= xin_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      pend_q  <= pend_d;
`ifdef BIQUAD_CASCADE_BYPASS_EN
      byp_q   <= byp_d;
`endif
      act_q   <= act_d;
      shd_q   <= shd_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
    end
  end

  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_sat   = sat_q;

endmodule

// File: tb/tb_biquad_cascade.sv
// Directed-vector bench for biquad_cascade: the driver pushes hand-computed
// expectations into a scoreboard that a separate monitor drains on o_valid.
module tb_biquad_cascade;
  import biquad_pkg::*;

  localparam int  DATA_W    = 24;
  localparam int  COEF_W    = 18;
  localparam int  COEF_FRAC = 14;
  localparam int  N_BANDS   = 3;
  localparam int  BAND_AW   = 4;
  localparam int  LAT       = 5 * N_BANDS + 1;
  localparam time T         = 10;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  typedef struct {
    sample_t data;
    time     t_acc;
    string   name;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #(T / 2) clk = ~clk;

  biquad_cascade_if #(
    .DATA_W  (DATA_W),
    .COEF_W  (COEF_W),
    .BAND_AW (BAND_AW)
`ifdef BIQUAD_CASCADE_BYPASS_EN
    , .N_BANDS (N_BANDS)
`endif
  ) bus ();

  biquad_cascade #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .N_BANDS   (N_BANDS),
    .BAND_AW   (BAND_AW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every o_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_o_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_data"}, bus.o_data, mon_e.data);
        check({mon_e.name, "_latency"},
              longint'(($time - mon_e.t_acc - T / 2) / T) + 1, LAT);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send_core(input string name, input sample_t x, input sample_t y,
                           input bit expect_out, input bit wr,
                           input logic [BAND_AW-1:0] band, input logic [2:0] idx,
                           input coef_t val);
    wait_ready();
    bus.i_valid = 1'b1;
    bus.i_data  = x;
    if (wr) begin
      bus.i_coef_we     = 1'b1;
      bus.i_coef_band   = band;
      bus.i_coef_idx    = idx;
      bus.i_coef        = val;
      bus.i_coef_commit = 1'b1;
    end
    @(posedge clk);
    if (expect_out) sb.push_back('{data: y, t_acc: $time, name: name});
    @(negedge clk);
    bus.i_valid       = 1'b0;
    bus.i_coef_we     = 1'b0;
    bus.i_coef_commit = 1'b0;
  endtask

  task automatic send(input string name, input sample_t x, input sample_t y);
    send_core(name, x, y, 1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic write_coef(input logic [BAND_AW-1:0] band, input logic [2:0] idx,
                            input coef_t val, input bit commit);
    bus.i_coef_we     = 1'b1;
    bus.i_coef_band   = band;
    bus.i_coef_idx    = idx;
    bus.i_coef        = val;
    bus.i_coef_commit = commit;
    @(negedge clk);
    bus.i_coef_we     = 1'b0;
    bus.i_coef_commit = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int low;
    bus.i_valid       = 1'b0;
    bus.i_data        = '0;
    bus.i_coef_we     = 1'b0;
    bus.i_coef_band   = '0;
    bus.i_coef_idx    = '0;
    bus.i_coef        = '0;
    bus.i_coef_commit = 1'b0;
`ifdef BIQUAD_CASCADE_BYPASS_EN
    bus.i_bypass      = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_o_valid", bus.o_valid, 0);
    check("reset_o_data", bus.o_data, 0);
    check("reset_o_sat", bus.o_sat, 0);
    check("reset_o_ready", bus.o_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Passthrough after reset; o_ready stays low until one cycle after o_valid.
    send("pass", 24'sh123456, 24'sh123456);
    low = 0;
    while (!bus.o_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
    check("ready_low_cycles", low, LAT);
    wait_drain();

    // Saturation with band0 gain 2.0.
    write_coef(0, 3'(B0), 18'sd32768, 1'b1);
    send("sat_pos", 24'sh400000, 24'sh7FFFFF);
    wait_drain();
    check("sat_sticky_set", bus.o_sat, 1);
    send("sat_neg", -24'sd4194305, 24'sh800000);
    wait_drain();
    check("sat_sticky_hold", bus.o_sat, 1);
    pulse_reset();
    check("sat_cleared_by_reset", bus.o_sat, 0);

    // Pure one-sample delay in band0.
    write_coef(0, 3'(B0), 18'sd0, 1'b0);
    write_coef(0, 3'(B1), 18'sd16384, 1'b1);
    send("fir0", 24'sd1000, 24'sd0);
    send("fir1", 24'sd0, 24'sd1000);
    send("fir2", 24'sd0, 24'sd0);
    wait_drain();

    // Round half-up on a 0.5 gain.
    pulse_reset();
    write_coef(0, 3'(B0), 18'sd8192, 1'b1);
    send("round_pos", 24'sd3, 24'sd2);
    send("round_neg", -24'sd3, -24'sd1);
    wait_drain();

    // First-order IIR y = x + 0.5*y1.
    pulse_reset();
    write_coef(0, 3'(A1), -18'sd8192, 1'b1);
    send("iir0", 24'sd1024, 24'sd1024);
    send("iir1", 24'sd0, 24'sd512);
    send("iir2", 24'sd0, 24'sd256);
    send("iir3", 24'sd0, 24'sd128);
    wait_drain();

    // Commit during S_MAC takes effect only from the next sample.
    pulse_reset();
    send("commit_cur", 24'sd100, 24'sd100);
    write_coef(0, 3'(B0), 18'sd32768, 1'b1);
    wait_drain();
    send("commit_next", 24'sd100, 24'sd200);
    wait_drain();

    // Write + commit + i_valid in one idle cycle applies to that sample.
    pulse_reset();
    send_core("commit_same", 24'sd100, 24'sd200, 1'b1, 1'b1, '0, 3'(B0), 18'sd32768);
    wait_drain();

    // Reset inside S_MAC aborts the sample and clears the history.
    pulse_reset();
    write_coef(0, 3'(A1), -18'sd8192, 1'b1);
    send("hist_prime", 24'sd1024, 24'sd1024);
    wait_drain();
    send_core("aborted", 24'sd2000, 24'sd0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    pulse_reset();
    check("abort_o_valid", bus.o_valid, 0);
    check("abort_o_data", bus.o_data, 0);
    check("abort_o_ready", bus.o_ready, 1);
    repeat (LAT + 4) @(negedge clk);
    write_coef(0, 3'(A1), -18'sd8192, 1'b1);
    send("clean_imp0", 24'sd1024, 24'sd1024);
    send("clean_imp1", 24'sd0, 24'sd512);
    wait_drain();

    // Out-of-range coefficient writes are dropped.
    pulse_reset();
    write_coef(0, 3'd5, 18'sd32768, 1'b0);
    write_coef(BAND_AW'(N_BANDS), 3'(B0), 18'sd32768, 1'b1);
    send("illegal_wr", 24'sd777, 24'sd777);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #(T * 50000);
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
